// File: rtl/rr_pkg.sv
// Shared constants and types for the round-robin grant consumer stage.
// Default requester count and payload width, FIFO depth, and the
// {data, src} entry layout used at the default configuration.
package rr_pkg;

  localparam int unsigned DEF_N      = 4;
  localparam int unsigned DEF_W      = 8;
  localparam int unsigned DEF_SW     = $clog2(DEF_N);
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DEF_W-1:0]  data;
    logic [DEF_SW-1:0] src;
  } entry_t;

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary encoder with lowest-index priority.
// Ports:
//   vec       in   N   one-hot (or malformed) vector
//   bin       out  SW  index of the lowest set bit (0 when vec is zero)
//   is_onehot out  1   high when exactly one bit of vec is set
module onehot_to_bin #(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [SW-1:0] bin,
  output logic          is_onehot
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    bin = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) bin = SW'(i);
    end
  end

  // Non-zero and a power of two.
  assign is_onehot = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/rr_grant_mux.sv
// Consumer stage behind round_robin_arbiter: captures the granted
// requester's payload and index into a 2-entry FIFO, acks the winner one
// cycle after capture, and back-pressures the arbiter through in_ready.
// Optional feature macro: RR_GRANT_MUX_ONEHOT_CHECK_EN (malformed grants
// are rejected and flagged on a sticky grant_err).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   grant         N    one-hot grant from the arbiter
//   grant_valid   1    grant qualifier
//   in_data       N*W  packed payloads, requester i at [i*W +: W]
//   in_ready      1    FIFO can accept a grant this cycle
//   ack           N    registered one-hot pulse to the captured requester
//   out_valid     1    head entry valid
//   out_data      W    head payload
//   out_src       SW   head source index
//   out_ready     1    downstream accepts the head
//   grant_err     1    sticky malformed-grant flag
module rr_grant_mux
  import rr_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   grant,
  input  logic           grant_valid,
  input  logic [N*W-1:0] in_data,
  output logic           in_ready,
  output logic [N-1:0]   ack,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  input  logic           out_ready,
  output logic           grant_err
);

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] src;
  } fifo_entry_t;

  fifo_entry_t      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  logic [SW-1:0]    idx;
  logic             grant_onehot;
  logic             grant_ok;
  logic             grant_err_nxt;
  logic             cap;
  logic             pop;
  fifo_entry_t      wr_entry;

  onehot_to_bin #(
    .N  (N),
    .SW (SW)
  ) u_onehot_to_bin (
    .vec       (grant),
    .bin       (idx),
    .is_onehot (grant_onehot)
  );

`ifdef RR_GRANT_MUX_ONEHOT_CHECK_EN
  // Only a clean one-hot grant is usable; anything else latches the error.
  assign grant_ok      = grant_onehot;
  assign grant_err_nxt = grant_err | (grant_valid & ~grant_onehot);
`else
  // Zero grants are ignored; multi-hot resolves to the lowest index.
  logic unused_onehot;
  assign unused_onehot = grant_onehot;
  assign grant_ok      = (grant != '0);
  assign grant_err_nxt = 1'b0;
`endif

  // in_ready is registered, so a full FIFO refuses even when popping.
  assign cap = grant_valid && in_ready && grant_ok;
  assign pop = out_valid && out_ready;

  assign wr_entry.data = in_data[idx*W +: W];
  assign wr_entry.src  = idx;

  // Occupancy update.
  always_comb begin
    count_nxt = count;
    unique case ({cap, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO state, flags derived from the next occupancy, and the ack pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem       <= '{default: '0};
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      ack       <= '0;
      grant_err <= 1'b0;
    end else begin
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      in_ready  <= (count_nxt != CNT_W'(FIFO_DEPTH));
      if (cap) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      ack       <= cap ? (N'(1) << idx) : '0;
      grant_err <= grant_err_nxt;
    end
  end

  // Head read straight from storage; stable until popped.
  assign out_data = mem[rd_ptr].data;
  assign out_src  = mem[rd_ptr].src;

endmodule

// File: doc/rr_grant_mux.md
Name: rr_grant_mux

Overview:
- Consumer stage directly downstream of round_robin_arbiter; takes its one-hot `grant`/`grant_valid` and the per-requester payload buses.
- Captures the winning requester's payload and source index into a 2-entry output FIFO with a valid/ready interface.
- Returns a registered one-hot `ack` to the winning requester, so it can drop or advance its request.
- Presents `in_ready` to the arbitration stage for back-pressure.

Parameters:
- N, 4, number of requesters; must match the arbiter's N; N >= 2.
- W, 8, payload width per requester in bits.
- SW, $clog2(N), source-index width; derived, not overridden.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- grant  input  N  one-hot grant from the arbiter.
- grant_valid  input  1  grant qualifier from the arbiter.
- in_data  input  N*W  packed payloads; requester i occupies bits [i*W +: W].
- in_ready  output  1  high when the FIFO can accept a grant this cycle.
- ack  output  N  registered one-hot pulse to the requester whose grant was captured.
- out_valid  output  1  head entry is valid.
- out_data  output  W  head payload.
- out_src  output  SW  head source index.
- out_ready  input  1  downstream accepts the head.
- grant_err  output  1  sticky malformed-grant flag; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset: on `rst` high at a clock edge, count=0, wr_ptr=rd_ptr=0, out_valid=0, out_data=0, out_src=0, ack=0, grant_err=0. Reset overrides all same-cycle events, including a mid-transfer capture.
- in_ready = (count != 2). It is purely a function of registered count and does not depend on out_ready.
- Capture condition: cap = grant_valid && in_ready && (grant != 0).
  - idx = index of the set bit in `grant`.
  - Entry written = {in_data[idx*W +: W], idx}.
- Pop condition: pop = out_valid && out_ready; the head entry is retired on that edge.
- Count update:
  - cap only: +1.
  - pop only: -1.
  - cap and pop in the same cycle: unchanged.
  - Pointers are 1 bit and wrap naturally.
- Output timing:
  - out_valid = (count != 0).
  - out_data and out_src are read from rd_ptr. The head is stable while out_valid && !out_ready.
  - Latency from grant to out_valid is 1 cycle when the FIFO is empty.
- ack timing:
  - ack = registered one-hot of idx on cap, asserted exactly 1 cycle after the capture edge.
  - ack is 0 in any cycle following a cycle without cap.
- Dropped grants:
  - grant_valid while in_ready=0: no capture, no ack.
  - The requester keeps req high and the arbiter re-grants later. No state change.
- grant_valid with grant==0: ignored, no ack.
- Multi-hot grant, feature off: the lowest set index wins and is captured and acked.
- Full with simultaneous pop: in_ready is still 0 that cycle (registered decision), so no capture.

Optional Feature:
- Macro: RR_GRANT_MUX_ONEHOT_CHECK_EN.
- Defined:
  - grant_valid with `grant` not exactly one-hot (zero or multi-hot) sets grant_err, which stays high until rst.
  - The offending grant is not captured and not acked.
- Undefined:
  - grant_err is held at 0.
  - Zero grant is ignored; multi-hot resolves to the lowest index as above.

Decomposition:
- Package rr_pkg holds:
  - Default N and W constants.
  - The FIFO depth constant FIFO_DEPTH=2.
  - Typedef entry_t = struct {logic [W-1:0] data; logic [SW-1:0] src;}.
- Sub-module onehot_to_bin (N to SW, lowest-index priority, plus an is_onehot output) is instantiated once. The same unit is reusable by the arbiter's own bench checkers.

Test Plan (N=4, W=8; in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0}):
- Reset then single grant: grant=0010, grant_valid=1 for 1 cycle, out_ready=1 → next cycle out_valid=1, out_data=B1, out_src=1, ack=0010 for exactly 1 cycle.
- Fill: out_ready=0 with grants 0001, 1000, 0100 on consecutive cycles → first two captured (A0/src0, D3/src3); in_ready=0 on the third, no ack=0100; then out_ready=1 pops A0 then D3 in order.
- Simultaneous push/pop: count=1, cap and pop in the same cycle → count stays 1, new head is the captured entry on the next cycle, no loss or duplication.
- Back-pressure hold: out_valid=1 with out_ready=0 for 5 cycles → out_data and out_src unchanged throughout.
- Reset mid-operation: count=2, rst=1 asserted in the same cycle as grant 0100 → next cycle count=0, out_valid=0, ack=0.
- Malformed grant: grant=0110 → feature off: src=1 captured, ack=0010; feature on: grant_err=1 sticky, nothing captured, ack=0.
